// File: rtl/uart_rx_pkg.sv
// Shared UART receive-path definitions: default word width, counter width helper, bit-order codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_rx_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  // Bit-order encoding carried on msb_first.
  localparam logic BIT_ORDER_LSB = 1'b0;
  localparam logic BIT_ORDER_MSB = 1'b1;

  // Frame collection phase, decoded from the bit counter.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } deser_state_t;

  // Width needed to count 0..dw inclusive.
  function automatic int cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// Frame bit counter: counts accepted bits, latches the frame length on the first bit, flags the last bit.
// Latency: bit_cnt registered (updates on the accepting edge); last_bit is combinational for the same edge.
// Backpressure: none; advances only when accept is high, clear wins over accept.
//
// Ports:
//   CLK, RST      clock, async active-low reset
//   clear         synchronous abort, forces the count to 0
//   accept        a bit is taken this cycle
//   frame_len     requested length, sampled only when a frame starts
//   bit_cnt       bits accepted so far in the current frame
//   last_bit      this cycle's accepted bit completes the frame
module deser_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_W      = cnt_w(DATA_WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             accept,
  input  logic [CNT_W-1:0] frame_len,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             last_bit
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(DATA_WIDTH);

  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_fix;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_idle;

  always_comb begin
    // Out-of-range lengths fall back to the full word width.
    len_fix  = ((frame_len == '0) || (frame_len > MAX_LEN)) ? MAX_LEN : frame_len;
    cnt_idle = (bit_cnt == '0);
    // The first bit must compare against the fresh length, since len_q
    // is only loaded on that same edge (this is what lets len 1 finish at once).
    len_eff  = cnt_idle ? len_fix : len_q;
    cnt_inc  = bit_cnt + CNT_W'(1);
    last_bit = accept && !clear && (cnt_inc == len_eff);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt <= '0;
      len_q   <= MAX_LEN;
    end else if (clear) begin
      bit_cnt <= '0;
    end else if (accept) begin
      if (cnt_idle) begin
        len_q <= len_fix;
      end
      bit_cnt <= last_bit ? '0 : cnt_inc;
    end
  end

endmodule

// File: rtl/deser_frame_unit.sv
// Serial-to-parallel deserializer with run-time frame length and bit order, atomic word output with even parity.
// Latency: P_DATA/par_bit/data_valid registered, valid the cycle after the edge accepting the last bit.
// Backpressure: none; one bit per deser_en cycle, deser_en low holds all state, clear aborts the frame.
//
// Ports:
//   CLK, RST      clock, async active-low reset
//   deser_en      sampled_bit is taken this cycle
//   sampled_bit   serial data bit
//   frame_len     bits per frame (0 or >DATA_WIDTH means DATA_WIDTH), latched at frame start
//   msb_first     bit order, latched at frame start
//   clear         synchronous abort of the frame in progress
//   P_DATA        last completed word, right-aligned, zero-extended
//   data_valid    one-cycle strobe when P_DATA updates
//   par_bit       XOR of the bits of P_DATA
//   busy          frame in progress
//   bit_cnt       bits accepted in the current frame
module deser_frame_unit
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_W      = cnt_w(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  deser_en,
  input  logic                  sampled_bit,
  input  logic [CNT_W-1:0]      frame_len,
  input  logic                  msb_first,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_bit,
  output logic                  busy,
  output logic [CNT_W-1:0]      bit_cnt
);

  logic                  last_bit;
  deser_state_t          state;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] sh_nxt;
  logic [DATA_WIDTH-1:0] bit_ext;
  logic                  par_acc;
  logic                  par_nxt;
  logic                  order_q;
  logic                  order_nxt;

  deser_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_cnt (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (clear),
    .accept    (deser_en),
    .frame_len (frame_len),
    .bit_cnt   (bit_cnt),
    .last_bit  (last_bit)
  );

  // The bit counter is the state register; the phase is a pure decode of it.
  always_comb begin
    state = (bit_cnt == '0) ? ST_IDLE : ST_COLLECT;
    busy  = (state == ST_COLLECT);
  end

  always_comb begin
    sh_nxt    = sh;
    par_nxt   = par_acc;
    order_nxt = order_q;
    bit_ext   = {{(DATA_WIDTH-1){1'b0}}, sampled_bit};
    if (clear) begin
      sh_nxt  = '0;
      par_nxt = 1'b0;
    end else if (deser_en) begin
      case (state)
        ST_IDLE: begin
          order_nxt = msb_first;
          sh_nxt    = bit_ext;
          par_nxt   = sampled_bit;
        end
        default: begin
          // LSB-first: bit k lands at position k; the register above k is
          // still zero, so an OR places it without a variable-index write.
          if (order_q == BIT_ORDER_MSB) begin
            sh_nxt = {sh[DATA_WIDTH-2:0], sampled_bit};
          end else begin
            sh_nxt = sh | (bit_ext << bit_cnt);
          end
          par_nxt = par_acc ^ sampled_bit;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh         <= '0;
      par_acc    <= 1'b0;
      order_q    <= BIT_ORDER_LSB;
      P_DATA     <= '0;
      par_bit    <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      sh         <= sh_nxt;
      par_acc    <= par_nxt;
      order_q    <= order_nxt;
      data_valid <= last_bit;
      // Whole word and parity move together, including the final bit.
      if (last_bit) begin
        P_DATA  <= sh_nxt;
        par_bit <= par_nxt;
      end
    end
  end

endmodule

// File: tb/tb_deser_frame_unit.sv
// Directed testbench for deser_frame_unit (DATA_WIDTH = 8).
// Latency: outputs sampled 1 time unit after the accepting edge.
// Backpressure: n/a.
module tb_deser_frame_unit;

  logic       CLK;
  logic       RST;
  logic       deser_en;
  logic       sampled_bit;
  logic [3:0] frame_len;
  logic       msb_first;
  logic       clear;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_bit;
  logic       busy;
  logic [3:0] bit_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;
  int cyc    = 0;

  deser_frame_unit dut (
    .CLK         (CLK),
    .RST         (RST),
    .deser_en    (deser_en),
    .sampled_bit (sampled_bit),
    .frame_len   (frame_len),
    .msb_first   (msb_first),
    .clear       (clear),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_bit     (par_bit),
    .busy        (busy),
    .bit_cnt     (bit_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;
  always @(negedge CLK) if (data_valid === 1'b1) pulses++;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Sends s[lo] .. s[hi-1], one per cycle, deser_en held high.
  task automatic send_bits(input logic [15:0] s, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      deser_en    = 1'b1;
      sampled_bit = s[i];
      tick();
    end
  endtask

  task automatic idle_cycle();
    deser_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b0; deser_en = 1'b0; sampled_bit = 1'b0; frame_len = 4'd8;
    msb_first = 1'b0; clear = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_chk++; if (P_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_pdata: got %h want 00", P_DATA); end
    n_chk++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    n_chk++; if (par_bit !== 1'b0) begin n_fail++; $display("FAIL reset_par: got %b want 0", par_bit); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bit_cnt); end
    @(negedge CLK);
    RST = 1'b1;
    tick();
  endtask

  // Stream 1,0,1,1,0,0,1,0 LSB-first -> 0x4D, parity 0.
  task automatic test_lsb8();
    int p0;
    p0 = pulses;
    frame_len = 4'd8; msb_first = 1'b0;
    send_bits(16'h004D, 0, 4);
    n_chk++; if (bit_cnt !== 4'd4) begin n_fail++; $display("FAIL lsb8_midcnt: got %0d want 4", bit_cnt); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lsb8_midbusy: got %b want 1", busy); end
    n_chk++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL lsb8_midvalid: got %b want 0", data_valid); end
    send_bits(16'h004D, 4, 8);
    n_chk++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL lsb8_valid: got %b want 1", data_valid); end
    n_chk++; if (P_DATA !== 8'h4D) begin n_fail++; $display("FAIL lsb8_data: got %h want 4d", P_DATA); end
    n_chk++; if (par_bit !== 1'b0) begin n_fail++; $display("FAIL lsb8_par: got %b want 0", par_bit); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lsb8_busy: got %b want 0", busy); end
    n_chk++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL lsb8_cnt: got %0d want 0", bit_cnt); end
    idle_cycle();
    n_chk++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL lsb8_vdrop: got %b want 0", data_valid); end
    n_chk++; if (P_DATA !== 8'h4D) begin n_fail++; $display("FAIL lsb8_hold: got %h want 4d", P_DATA); end
    n_chk++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL lsb8_pulses: got %0d want 1", pulses - p0); end
  endtask

  // Same stream MSB-first -> 0xB2, parity 0.
  task automatic test_msb8();
    frame_len = 4'd8; msb_first = 1'b1;
    send_bits(16'h004D, 0, 8);
    n_chk++; if (P_DATA !== 8'hB2) begin n_fail++; $display("FAIL msb8_data: got %h want b2", P_DATA); end
    n_chk++; if (par_bit !== 1'b0) begin n_fail++; $display("FAIL msb8_par: got %b want 0", par_bit); end
    n_chk++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL msb8_valid: got %b want 1", data_valid); end
    idle_cycle();
    msb_first = 1'b0;
  endtask

  // Length 5, bits 1,1,1,0,1 with enable every other cycle -> 0x17, parity 0.
  task automatic test_len5_gated();
    logic [4:0] s;
    int p0;
    s = 5'b10111;
    p0 = pulses;
    frame_len = 4'd5; msb_first = 1'b0;
    for (int i = 0; i < 5; i++) begin
      deser_en = 1'b1; sampled_bit = s[i];
      tick();
      deser_en = 1'b0; sampled_bit = ~s[i];
      tick();
      if (i == 1) begin
        n_chk++; if (bit_cnt !== 4'd2) begin n_fail++; $display("FAIL len5_hold: got %0d want 2", bit_cnt); end
      end
    end
    n_chk++; if (P_DATA !== 8'h17) begin n_fail++; $display("FAIL len5_data: got %h want 17", P_DATA); end
    n_chk++; if (par_bit !== 1'b0) begin n_fail++; $display("FAIL len5_par: got %b want 0", par_bit); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len5_busy: got %b want 0", busy); end
    idle_cycle();
    n_chk++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL len5_pulses: got %0d want 1", pulses - p0); end
  endtask

  // frame_len 0 and 12 both mean 8 bits; msb_first flipped after bit 3 is ignored.
  task automatic test_len_fix();
    frame_len = 4'd0; msb_first = 1'b0;
    send_bits(16'h00C3, 0, 3);
    msb_first = 1'b1;
    send_bits(16'h00C3, 3, 7);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL len0_busy7: got %b want 1", busy); end
    send_bits(16'h00C3, 7, 8);
    n_chk++; if (P_DATA !== 8'hC3) begin n_fail++; $display("FAIL len0_data: got %h want c3", P_DATA); end
    n_chk++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL len0_valid: got %b want 1", data_valid); end
    idle_cycle();
    frame_len = 4'd12; msb_first = 1'b0;
    send_bits(16'h0097, 0, 3);
    msb_first = 1'b1; frame_len = 4'd3;
    send_bits(16'h0097, 3, 8);
    n_chk++; if (P_DATA !== 8'h97) begin n_fail++; $display("FAIL len12_data: got %h want 97", P_DATA); end
    n_chk++; if (par_bit !== 1'b1) begin n_fail++; $display("FAIL len12_par: got %b want 1", par_bit); end
    n_chk++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL len12_valid: got %b want 1", data_valid); end
    idle_cycle();
    frame_len = 4'd8; msb_first = 1'b0;
  endtask

  // clear together with bit 8 aborts; next frame of all ones -> 0xFF.
  task automatic test_clear();
    int p0;
    send_bits(16'h004D, 0, 8);
    idle_cycle();
    p0 = pulses;
    send_bits(16'h00FF, 0, 7);
    deser_en = 1'b1; sampled_bit = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    n_chk++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", data_valid); end
    n_chk++; if (P_DATA !== 8'h4D) begin n_fail++; $display("FAIL clr_hold: got %h want 4d", P_DATA); end
    n_chk++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d want 0", bit_cnt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b want 0", busy); end
    send_bits(16'h00FF, 0, 8);
    n_chk++; if (P_DATA !== 8'hFF) begin n_fail++; $display("FAIL clr_next: got %h want ff", P_DATA); end
    n_chk++; if (par_bit !== 1'b0) begin n_fail++; $display("FAIL clr_par: got %b want 0", par_bit); end
    idle_cycle();
    n_chk++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL clr_pulses: got %0d want 1", pulses - p0); end
  endtask

  // Async reset after bit 4, then a clean 0x3C frame.
  task automatic test_async_reset();
    send_bits(16'h0055, 0, 4);
    deser_en = 1'b0;
    #3;
    RST = 1'b0;
    #1;
    n_chk++; if (P_DATA !== 8'h00) begin n_fail++; $display("FAIL arst_pdata: got %h want 00", P_DATA); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
    n_chk++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d want 0", bit_cnt); end
    n_chk++; if (par_bit !== 1'b0) begin n_fail++; $display("FAIL arst_par: got %b want 0", par_bit); end
    @(negedge CLK);
    RST = 1'b1;
    tick();
    send_bits(16'h003C, 0, 8);
    n_chk++; if (P_DATA !== 8'h3C) begin n_fail++; $display("FAIL arst_next: got %h want 3c", P_DATA); end
    n_chk++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL arst_valid: got %b want 1", data_valid); end
    idle_cycle();
  endtask

  // 0xA5 then 0x5A, no idle cycle: pulses 8 cycles apart.
  task automatic test_back_to_back();
    int c1;
    int c2;
    send_bits(16'h00A5, 0, 8);
    c1 = cyc;
    n_chk++; if (P_DATA !== 8'hA5) begin n_fail++; $display("FAIL b2b_first: got %h want a5", P_DATA); end
    n_chk++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid1: got %b want 1", data_valid); end
    send_bits(16'h005A, 0, 1);
    n_chk++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_vdrop: got %b want 0", data_valid); end
    n_chk++; if (bit_cnt !== 4'd1) begin n_fail++; $display("FAIL b2b_cnt1: got %0d want 1", bit_cnt); end
    send_bits(16'h005A, 1, 8);
    c2 = cyc;
    n_chk++; if (P_DATA !== 8'h5A) begin n_fail++; $display("FAIL b2b_second: got %h want 5a", P_DATA); end
    n_chk++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2: got %b want 1", data_valid); end
    n_chk++; if (c2 - c1 !== 8) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 8", c2 - c1); end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_lsb8();
    test_msb8();
    test_len5_gated();
    test_len_fix();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
